// File: rtl/adc_row_col_decoder_pkg.sv
// Shared widths, field layout and reset drive values for the CDAC row/column decoder.
package adc_row_col_decoder_pkg;

  localparam int CODE_W = 12;
  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int NBIN   = 3;
  localparam int IDX_W  = 4;

  // Field view of a DAC code, MSB first so a plain cast splits it.
  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [NBIN-1:0]  bin;
    logic             lsb;
  } code_fields_t;

  // Complete set of active-low drive lines, held in one register.
  typedef struct packed {
    logic [ROWS-1:0] row_n;
    logic [ROWS-1:0] rowon_n;
    logic [COLS-1:0] col_n;
    logic [NBIN-1:0] bincap_n;
    logic            c0p_n;
    logic            c0n_n;
  } drive_t;

  localparam logic [ROWS-1:0] RST_ROW_N    = 16'hFFFE;
  localparam logic [ROWS-1:0] RST_ROWON_N  = 16'hFFFF;
  localparam logic [COLS-1:0] RST_COL_N    = 16'hFFFF;
  localparam logic [NBIN-1:0] RST_BINCAP_N = 3'b111;
  localparam logic            RST_C0P_N    = 1'b1;
  localparam logic            RST_C0N_N    = 1'b0;

  localparam drive_t RST_DRIVE = '{
    row_n:    RST_ROW_N,
    rowon_n:  RST_ROWON_N,
    col_n:    RST_COL_N,
    bincap_n: RST_BINCAP_N,
    c0p_n:    RST_C0P_N,
    c0n_n:    RST_C0N_N
  };

  function automatic code_fields_t split_code(input logic [CODE_W-1:0] code);
    return code_fields_t'(code);
  endfunction

endpackage

// File: rtl/adc_therm4_decoder.sv
// 4-bit index to 16-bit "less-than" thermometer and "equal" one-hot vectors (active-high).
module adc_therm4_decoder
  import adc_row_col_decoder_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [15:0]      lt,
  output logic [15:0]      eq
);

  always_comb begin
    lt = '0;
    eq = '0;
    for (int i = 0; i < 16; i++) begin
      lt[i] = (4'(i) < idx);
      eq[i] = (4'(i) == idx);
    end
  end

endmodule

// File: rtl/adc_row_col_decoder.sv
// Registered decoder from a 12-bit DAC code to active-low unary-matrix, binary and split-LSB cap drives.
module adc_row_col_decoder
  import adc_row_col_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] data,
  output logic [ROWS-1:0]   row_n,
  output logic [ROWS-1:0]   rowon_n,
  output logic [COLS-1:0]   col_n,
  output logic [NBIN-1:0]   bincap_n,
  output logic              c0p_n,
  output logic              c0n_n
);

  code_fields_t    fields;
  logic [ROWS-1:0] row_lt;
  logic [ROWS-1:0] row_eq;
  logic [COLS-1:0] col_lt;
  logic [COLS-1:0] col_eq_unused;
  drive_t          drive_d;
  drive_t          drive_q;

  assign fields = split_code(data);

  adc_therm4_decoder u_row_dec (
    .idx (fields.row),
    .lt  (row_lt),
    .eq  (row_eq)
  );

  // Only the thermometer is needed for columns; the partial row is picked by row_eq.
  adc_therm4_decoder u_col_dec (
    .idx (fields.col),
    .lt  (col_lt),
    .eq  (col_eq_unused)
  );

  always_comb begin
    drive_d          = RST_DRIVE;
    drive_d.row_n    = ~row_eq;
    drive_d.rowon_n  = ~row_lt;
    drive_d.col_n    = ~col_lt;
    drive_d.bincap_n = ~fields.bin;
    drive_d.c0p_n    = ~fields.lsb;
    drive_d.c0n_n    = fields.lsb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drive_q <= RST_DRIVE;
    end else begin
      drive_q <= drive_d;
    end
  end

  assign row_n    = drive_q.row_n;
  assign rowon_n  = drive_q.rowon_n;
  assign col_n    = drive_q.col_n;
  assign bincap_n = drive_q.bincap_n;
  assign c0p_n    = drive_q.c0p_n;
  assign c0n_n    = drive_q.c0n_n;

endmodule

// File: tb/tb_adc_row_col_decoder.sv
// Directed and swept checks of the CDAC decoder against hand values and a small reference model.
module tb_adc_row_col_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] data = 12'h000;
  logic [15:0] row_n;
  logic [15:0] rowon_n;
  logic [15:0] col_n;
  logic [2:0]  bincap_n;
  logic        c0p_n;
  logic        c0n_n;

  int checks = 0;
  int failures = 0;

  adc_row_col_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .row_n    (row_n),
    .rowon_n  (rowon_n),
    .col_n    (col_n),
    .bincap_n (bincap_n),
    .c0p_n    (c0p_n),
    .c0n_n    (c0n_n)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_row, input logic [15:0] e_rowon,
                           input logic [15:0] e_col, input logic [2:0] e_bin,
                           input logic e_p, input logic e_n);
    check_output({tag, ".row_n"},    row_n,              e_row);
    check_output({tag, ".rowon_n"},  rowon_n,            e_rowon);
    check_output({tag, ".col_n"},    col_n,              e_col);
    check_output({tag, ".bincap_n"}, {13'b0, bincap_n},  {13'b0, e_bin});
    check_output({tag, ".c0p_n"},    {15'b0, c0p_n},     {15'b0, e_p});
    check_output({tag, ".c0n_n"},    {15'b0, c0n_n},     {15'b0, e_n});
  endtask

  // Drive inputs away from the edge, clock once, then settle before sampling.
  task automatic apply_stimulus(input logic r, input logic [11:0] code);
    rst  = r;
    data = code;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] therm_n(input logic [3:0] n);
    logic [15:0] v;
    v = 16'hFFFF;
    for (int i = 0; i < 16; i++)
      if (i < int'(n)) v[i] = 1'b0;
    return v;
  endfunction

  task automatic check_model(input logic [11:0] code);
    logic [3:0]  r;
    logic [3:0]  c;
    logic [15:0] e_row;
    int          on_cells;
    r     = code[11:8];
    c     = code[7:4];
    e_row = 16'hFFFF;
    e_row[r] = 1'b0;
    check_all($sformatf("sweep_%03h", code), e_row, therm_n(r), therm_n(c),
              ~code[3:1], ~code[0], code[0]);
    on_cells = 0;
    for (int rr = 0; rr < 16; rr++)
      for (int cc = 0; cc < 16; cc++)
        if (!rowon_n[rr] || (!row_n[rr] && !col_n[cc])) on_cells++;
    check_output($sformatf("cells_%03h", code), 16'(on_cells), {8'h00, code[11:4]});
    check_output($sformatf("onehot_%03h", code), 16'($countones(~row_n)), 16'd1);
    check_output($sformatf("c0comp_%03h", code), {15'b0, c0p_n ^ c0n_n}, 16'd1);
  endtask

  initial begin
    $display("[TB] start");

    apply_stimulus(1'b1, 12'hABC);
    check_all("reset1", 16'hFFFE, 16'hFFFF, 16'hFFFF, 3'b111, 1'b1, 1'b0);
    apply_stimulus(1'b1, 12'hABC);
    check_all("reset2", 16'hFFFE, 16'hFFFF, 16'hFFFF, 3'b111, 1'b1, 1'b0);

    apply_stimulus(1'b0, 12'h123);
    check_all("code_123", 16'hFFFD, 16'hFFFE, 16'hFFFC, 3'b110, 1'b0, 1'b1);

    apply_stimulus(1'b0, 12'hFFF);
    check_all("code_FFF", 16'h7FFF, 16'h8000, 16'h8000, 3'b000, 1'b0, 1'b1);
    apply_stimulus(1'b0, 12'hFFD);
    check_all("code_FFD", 16'h7FFF, 16'h8000, 16'h8000, 3'b001, 1'b0, 1'b1);

    apply_stimulus(1'b0, 12'h0FF);
    check_all("wrap_0FF", 16'hFFFE, 16'hFFFF, 16'h8000, 3'b000, 1'b0, 1'b1);
    apply_stimulus(1'b0, 12'h100);
    check_all("wrap_100", 16'hFFFD, 16'hFFFE, 16'hFFFF, 3'b111, 1'b1, 1'b0);

    for (int k = 0; k < 4096; k++) begin
      if (k == 12'h800) begin
        apply_stimulus(1'b1, 12'h800);
        check_all("midreset", 16'hFFFE, 16'hFFFF, 16'hFFFF, 3'b111, 1'b1, 1'b0);
      end
      apply_stimulus(1'b0, 12'(k));
      check_model(12'(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
